// File: rtl/traffic_sequencer_if.sv
// Signal bundle between the traffic sequencer and its environment.
// The controller side (master) drives enable, tick and button; the
// sequencer side (slave) drives lamps, pending flag and debug state.
interface traffic_sequencer_if;
  logic       En;
  logic       Tick1;
  logic       PedBtn;
  logic [2:0] NS;
  logic [2:0] EW;
  logic       Walk;
  logic       PedPend;
  logic [2:0] State;

  modport master (
    output En, Tick1, PedBtn,
    input  NS, EW, Walk, PedPend, State
  );

  modport slave (
    input  En, Tick1, PedBtn,
    output NS, EW, Walk, PedPend, State
  );
endinterface

// File: rtl/traffic_sequencer.sv
// Traffic-light sequencer: NS/EW phases with all-red clearance and an
// optional pedestrian walk phase, timed by a 1 Hz strobe.

// One asynchronous input lane: 2-flop synchronizer, then a registered
// rising-edge pulse. The pulse is high in the third cycle counted from
// the edge that first samples the input high, and lasts one cycle.
module traffic_sequencer_sync (
  input  logic ClkIn,
  input  logic Clr_,
  input  logic a_i,
  output logic pulse_o
);
  logic s1_q, s2_q, prev_q, pulse_q;

  // synchronize, remember the last synced level, register the rising edge
  always_ff @(posedge ClkIn or negedge Clr_) begin
    if (!Clr_) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= a_i;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      pulse_q <= s2_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

module traffic_sequencer #(
  parameter int unsigned GREEN_T  = 20,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned RED_T    = 2,
  parameter int unsigned WALK_T   = 10
) (
  input  logic                 ClkIn,
  input  logic                 Clr_,
  traffic_sequencer_if.slave   bus
);
  localparam int NUM_LANES = 2;   // lane 0: Tick1, lane 1: PedBtn

  localparam logic [7:0] GREEN_D  = 8'(GREEN_T);
  localparam logic [7:0] YELLOW_D = 8'(YELLOW_T);
  localparam logic [7:0] RED_D    = 8'(RED_T);
  localparam logic [7:0] WALK_D   = 8'(WALK_T);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED2  = 3'd5,
    WALK      = 3'd6
  } state_e;

  logic [NUM_LANES-1:0] lane_in;
  logic [NUM_LANES-1:0] lane_pulse;
  logic                 sec_p, ped_p;

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] ns_q, ns_d, ew_q, ew_d;
  logic       walk_q, walk_d;
  logic       pend_q, pend_d;
  logic       adv;

  assign lane_in = {bus.PedBtn, bus.Tick1};

  traffic_sequencer_sync u_sync [NUM_LANES-1:0] (
    .ClkIn   (ClkIn),
    .Clr_    (Clr_),
    .a_i     (lane_in),
    .pulse_o (lane_pulse)
  );

  assign sec_p = lane_pulse[0];
  assign ped_p = lane_pulse[1];

  // duration loaded into the timer when a state is entered
  function automatic logic [7:0] dur(input state_e s);
    case (s)
      NS_GREEN, EW_GREEN:   dur = GREEN_D;
      NS_YELLOW, EW_YELLOW: dur = YELLOW_D;
      WALK:                 dur = WALK_D;
      default:              dur = RED_D;
    endcase
  endfunction

  // registered state, timer, lamps and pedestrian latch; reset parks in ALL_RED2
  always_ff @(posedge ClkIn or negedge Clr_) begin
    if (!Clr_) begin
      state_q <= ALL_RED2;
      timer_q <= RED_D;
      ns_q    <= LAMP_R;
      ew_q    <= LAMP_R;
      walk_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      walk_q  <= walk_d;
      pend_q  <= pend_d;
    end
  end

  // next state/timer; lamps derive from the next state so they switch with State
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    adv     = 1'b0;
    ns_d    = LAMP_R;
    ew_d    = LAMP_R;
    walk_d  = 1'b0;

    // a strobe while disabled is simply dropped
    if (bus.En && sec_p) begin
      if (timer_q <= 8'd1) begin
        adv = 1'b1;
        case (state_q)
          NS_GREEN:  state_d = NS_YELLOW;
          NS_YELLOW: state_d = ALL_RED1;
          ALL_RED1:  state_d = EW_GREEN;
          EW_GREEN:  state_d = EW_YELLOW;
          EW_YELLOW: state_d = ALL_RED2;
          ALL_RED2:  state_d = pend_q ? WALK : NS_GREEN;
          default:   state_d = NS_GREEN;
        endcase
        timer_d = dur(state_d);
      end else begin
        timer_d = timer_q - 8'd1;
      end
    end

    case (state_d)
      NS_GREEN:  ns_d   = LAMP_G;
      NS_YELLOW: ns_d   = LAMP_Y;
      EW_GREEN:  ew_d   = LAMP_G;
      EW_YELLOW: ew_d   = LAMP_Y;
      WALK:      walk_d = 1'b1;
      default:   ;
    endcase

    // entering WALK serves the request and swallows a coincident press
    if (adv && state_d == WALK) pend_d = 1'b0;
    else if (ped_p)             pend_d = 1'b1;
    else                        pend_d = pend_q;
  end

  assign bus.State   = state_q;
  assign bus.NS      = ns_q;
  assign bus.EW      = ew_q;
  assign bus.Walk    = walk_q;
  assign bus.PedPend = pend_q;
endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed bench for traffic_sequencer with short phase durations.
module tb_traffic_sequencer;
  logic ClkIn = 1'b0;
  logic Clr_  = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   inv_err = 0;

  logic [2:0] mid_state, post_state;
  logic       post_pp, pp_mid, pp_post;

  localparam logic [2:0] SEQ [13] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2,
                                      3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};

  traffic_sequencer_if bus ();

  traffic_sequencer #(
    .GREEN_T (3),
    .YELLOW_T(2),
    .RED_T   (1),
    .WALK_T  (2)
  ) dut (
    .ClkIn (ClkIn),
    .Clr_  (Clr_),
    .bus   (bus.slave)
  );

  always #5 ClkIn = ~ClkIn;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ns_exp(input logic [2:0] s);
    ns_exp = (s == 3'd0) ? 3'b001 : (s == 3'd1) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] ew_exp(input logic [2:0] s);
    ew_exp = (s == 3'd3) ? 3'b001 : (s == 3'd4) ? 3'b010 : 3'b100;
  endfunction

  // every cycle: never both directions non-red, Walk exactly in WALK
  always @(negedge ClkIn) begin
    if (bus.NS != 3'b100 && bus.EW != 3'b100) inv_err++;
    if (bus.Walk != (bus.State == 3'd6))      inv_err++;
  end

  // one Tick1 period: high 4 cycles, low 36; optional aligned button press
  task automatic sec(input logic ped);
    @(negedge ClkIn);
    bus.Tick1  = 1'b1;
    bus.PedBtn = ped;
    repeat (3) @(negedge ClkIn);
    mid_state = bus.State;
    @(negedge ClkIn);
    post_state = bus.State;
    post_pp    = bus.PedPend;
    bus.Tick1  = 1'b0;
    bus.PedBtn = 1'b0;
    repeat (36) @(negedge ClkIn);
  endtask

  task automatic press();
    @(negedge ClkIn);
    bus.PedBtn = 1'b1;
    repeat (3) @(negedge ClkIn);
    pp_mid = bus.PedPend;
    @(negedge ClkIn);
    pp_post = bus.PedPend;
    bus.PedBtn = 1'b0;
    repeat (4) @(negedge ClkIn);
  endtask

  task automatic secs(input int n);
    for (int i = 0; i < n; i++) sec(1'b0);
  endtask

  task automatic run_seq();
    chk("seq_st0", 8'(bus.State), 8'd5);
    chk("seq_ns0", 8'(bus.NS), 8'h4);
    for (int i = 0; i < 13; i++) begin
      sec(1'b0);
      if (i == 0) begin
        chk("secp_lat_pre", 8'(mid_state), 8'd5);
        chk("secp_lat_post", 8'(post_state), 8'd0);
      end
      chk("seq_st", 8'(bus.State), 8'(SEQ[i]));
      chk("seq_ns", 8'(bus.NS), 8'(ns_exp(SEQ[i])));
      chk("seq_ew", 8'(bus.EW), 8'(ew_exp(SEQ[i])));
    end
  endtask

  initial begin
    bus.En = 1'b1;
    bus.Tick1 = 1'b0;
    bus.PedBtn = 1'b0;

    // reset values and the basic cycle
    repeat (3) @(negedge ClkIn);
    chk("rst_state", 8'(bus.State), 8'd5);
    chk("rst_ns", 8'(bus.NS), 8'h4);
    chk("rst_ew", 8'(bus.EW), 8'h4);
    chk("rst_walk", 8'(bus.Walk), 8'd0);
    chk("rst_pend", 8'(bus.PedPend), 8'd0);
    Clr_ = 1'b1;
    run_seq();                       // ends in NS_GREEN, timer 3

    // freeze with En=0 at timer 2; press still latches
    sec(1'b0);
    chk("en_pre", 8'(bus.State), 8'd0);
    bus.En = 1'b0;
    press();
    chk("pedp_lat_pre", 8'(pp_mid), 8'd0);
    chk("pedp_lat_post", 8'(pp_post), 8'd1);
    for (int i = 0; i < 5; i++) begin
      sec(1'b0);
      chk("frz_state", 8'(bus.State), 8'd0);
      chk("frz_ns", 8'(bus.NS), 8'h1);
    end
    bus.En = 1'b1;
    sec(1'b0);
    chk("resume1", 8'(bus.State), 8'd0);
    sec(1'b0);
    chk("resume2", 8'(bus.State), 8'd1);
    chk("resume2_ns", 8'(bus.NS), 8'h2);
    secs(3);
    chk("to_ewg", 8'(bus.State), 8'd3);
    chk("to_ewg_ew", 8'(bus.EW), 8'h1);

    // press in EW_GREEN, walk phase after ALL_RED2
    press();
    chk("ewg_pend", 8'(pp_post), 8'd1);
    secs(5);
    chk("pre_walk", 8'(bus.State), 8'd5);
    sec(1'b0);
    chk("walk_entry_pp", 8'(post_pp), 8'd0);
    chk("walk_st", 8'(bus.State), 8'd6);
    chk("walk_lamp", 8'(bus.Walk), 8'd1);
    chk("walk_ns", 8'(bus.NS), 8'h4);
    chk("walk_ew", 8'(bus.EW), 8'h4);
    chk("walk_pend", 8'(bus.PedPend), 8'd0);
    sec(1'b0);
    chk("walk_st2", 8'(bus.State), 8'd6);
    sec(1'b0);
    chk("post_walk", 8'(bus.State), 8'd0);
    chk("post_walk_w", 8'(bus.Walk), 8'd0);
    chk("post_walk_ns", 8'(bus.NS), 8'h1);

    // press aligned with WALK entry is absorbed; press in WALK re-arms
    press();
    chk("p3_pre", 8'(pp_mid), 8'd0);
    chk("p3_post", 8'(pp_post), 8'd1);
    secs(11);
    chk("p3_ar2", 8'(bus.State), 8'd5);
    sec(1'b1);
    chk("align_st", 8'(post_state), 8'd6);
    chk("align_pp", 8'(post_pp), 8'd0);
    chk("align_pp_end", 8'(bus.PedPend), 8'd0);
    press();
    chk("inwalk_pre", 8'(pp_mid), 8'd0);
    chk("inwalk_post", 8'(pp_post), 8'd1);
    secs(2);
    chk("walk_exit", 8'(bus.State), 8'd0);
    chk("walk_exit_pp", 8'(bus.PedPend), 8'd1);
    secs(12);
    chk("walk_again", 8'(bus.State), 8'd6);
    chk("walk_again_pp", 8'(bus.PedPend), 8'd0);
    secs(2);
    chk("walk_again_x", 8'(bus.State), 8'd0);

    // async reset in EW_YELLOW, then full restart
    secs(6);
    press();
    secs(3);
    chk("pre_rst_st", 8'(bus.State), 8'd4);
    chk("pre_rst_pp", 8'(bus.PedPend), 8'd1);
    @(negedge ClkIn);
    #2 Clr_ = 1'b0;
    #1;
    chk("arst_state", 8'(bus.State), 8'd5);
    chk("arst_ns", 8'(bus.NS), 8'h4);
    chk("arst_ew", 8'(bus.EW), 8'h4);
    chk("arst_walk", 8'(bus.Walk), 8'd0);
    chk("arst_pend", 8'(bus.PedPend), 8'd0);
    @(negedge ClkIn);
    Clr_ = 1'b1;
    run_seq();

    chk("invariant", 8'(inv_err > 255 ? 255 : inv_err), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
